fsm_esteira_arbitro: RTL and testbench

Conveyor-motor scheduler for the bottling line. It owns the single conveyor motor and grants it to one of three move commands issued by the master sequencer: move to filling, move to QC, move to final. For each granted move it runs the motor until the destination sensor is detected, lets the belt settle, then returns a one-cycle completion pulse on the matching `esteira_concluida_*` line. Sits between the master FSM and the physical switches/LEDs, replacing three independent conveyor slaves.

---
 rtl/fsm_esteira_arbitro.sv | 224 ++++++++++++++++++++++
 tb/tb_fsm_esteira_arbitro.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/fsm_esteira_arbitro.sv
// Conveyor motor scheduler: grants the single belt motor to one of three move commands.
// Define ESTEIRA_WATCHDOG_EN to build the motor-on timeout counter and the ERRO state.
module fsm_esteira_arbitro #(
  parameter int unsigned PARADA_CICLOS  = 25_000_000,
  parameter int unsigned TIMEOUT_CICLOS = 500_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_mover_para_enchimento,
  input  logic       cmd_mover_para_cq,
  input  logic       cmd_mover_para_final,
  input  logic       sensor_enchimento,
  input  logic       sensor_cq,
  input  logic       sensor_final,
  input  logic       alarme_rolha,
  output logic       motor_esteira,
  output logic       esteira_concluida_enchimento,
  output logic       esteira_concluida_cq,
  output logic       esteira_concluida_final,
  output logic [1:0] destino_atual,
  output logic       erro_timeout
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MOVENDO,
    S_PAUSA,
    S_PARADA,
    S_CONCLUIDO,
    S_AGUARDA_LIBERA,
    S_ERRO
  } estado_t;

  localparam int unsigned PW = (PARADA_CICLOS > 1) ? $clog2(PARADA_CICLOS) : 1;
  localparam logic [PW-1:0] PARADA_LAST = PW'(PARADA_CICLOS - 1);

  estado_t       state_q, state_d;
  logic [1:0]    dest_q, dest_d;
  logic [PW-1:0] parada_q, parada_d;
  logic [2:0]    sync1_q, sync1_d;
  logic [2:0]    sync2_q, sync2_d;
  logic          motor_q, motor_d;
  logic [2:0]    concl_q, concl_d;
  logic [1:0]    destino_q, destino_d;

`ifdef ESTEIRA_WATCHDOG_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CICLOS);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CICLOS - 1);

  logic [TW-1:0] tmo_q, tmo_d;
  logic          erro_q, erro_d;
`else
  logic          unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CICLOS;
`endif

  logic [2:0] cmd_vec;
  logic       cmd_granted;
  logic       sensor_granted;

  assign cmd_vec = {cmd_mover_para_final, cmd_mover_para_cq, cmd_mover_para_enchimento};

  always_comb begin : sync_comb
    sync1_d = {sensor_final, sensor_cq, sensor_enchimento};
    sync2_d = sync1_q;
  end

  // Only the granted destination's command and synchronized sensor matter.
  always_comb begin : grant_sel
    cmd_granted    = 1'b0;
    sensor_granted = 1'b0;
    case (dest_q)
      2'd0: begin
        cmd_granted    = cmd_vec[0];
        sensor_granted = sync2_q[0];
      end
      2'd1: begin
        cmd_granted    = cmd_vec[1];
        sensor_granted = sync2_q[1];
      end
      2'd2: begin
        cmd_granted    = cmd_vec[2];
        sensor_granted = sync2_q[2];
      end
      default: begin
        cmd_granted    = 1'b0;
        sensor_granted = 1'b0;
      end
    endcase
  end

  always_comb begin : next_state
    state_d  = state_q;
    dest_d   = dest_q;
    parada_d = parada_q;
`ifdef ESTEIRA_WATCHDOG_EN
    tmo_d    = tmo_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (|cmd_vec) begin
          state_d = S_MOVENDO;
          if (cmd_vec[0]) begin
            dest_d = 2'd0;
          end else if (cmd_vec[1]) begin
            dest_d = 2'd1;
          end else begin
            dest_d = 2'd2;
          end
`ifdef ESTEIRA_WATCHDOG_EN
          tmo_d = '0;
`endif
        end
      end
      S_MOVENDO: begin
`ifdef ESTEIRA_WATCHDOG_EN
        // Saturate so a pause taken on the last allowed cycle still faults on resume.
        if (tmo_q != TMO_LAST) begin
          tmo_d = tmo_q + TW'(1);
        end
`endif
        if (!cmd_granted) begin
          state_d = S_IDLE;
        end else if (sensor_granted) begin
          state_d  = S_PARADA;
          parada_d = '0;
        end else if (alarme_rolha) begin
          state_d = S_PAUSA;
`ifdef ESTEIRA_WATCHDOG_EN
        end else if (tmo_q == TMO_LAST) begin
          state_d = S_ERRO;
`endif
        end
      end
      S_PAUSA: begin
        if (!cmd_granted) begin
          state_d = S_IDLE;
        end else if (!alarme_rolha) begin
          state_d = S_MOVENDO;
        end
      end
      S_PARADA: begin
        if (parada_q == PARADA_LAST) begin
          state_d = S_CONCLUIDO;
        end else begin
          parada_d = parada_q + PW'(1);
        end
      end
      S_CONCLUIDO: begin
        state_d = S_AGUARDA_LIBERA;
      end
      S_AGUARDA_LIBERA: begin
        if (!cmd_granted) begin
          state_d = S_IDLE;
        end
      end
      S_ERRO: begin
        state_d = S_ERRO;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin : output_comb
    motor_d   = (state_q == S_MOVENDO);
    destino_d = (state_q == S_IDLE) ? 2'd3 : dest_q;
    concl_d   = '0;
    if (state_q == S_CONCLUIDO) begin
      case (dest_q)
        2'd0:    concl_d = 3'b001;
        2'd1:    concl_d = 3'b010;
        2'd2:    concl_d = 3'b100;
        default: concl_d = 3'b000;
      endcase
    end
`ifdef ESTEIRA_WATCHDOG_EN
    erro_d = (state_q == S_ERRO);
`endif
  end

  always_ff @(posedge clk) begin : state_reg
    if (reset) begin
      state_q   <= S_IDLE;
      dest_q    <= 2'd3;
      parada_q  <= '0;
      sync1_q   <= '0;
      sync2_q   <= '0;
      motor_q   <= 1'b0;
      concl_q   <= '0;
      destino_q <= 2'd3;
`ifdef ESTEIRA_WATCHDOG_EN
      tmo_q     <= '0;
      erro_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      dest_q    <= dest_d;
      parada_q  <= parada_d;
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      motor_q   <= motor_d;
      concl_q   <= concl_d;
      destino_q <= destino_d;
`ifdef ESTEIRA_WATCHDOG_EN
      tmo_q     <= tmo_d;
      erro_q    <= erro_d;
`endif
    end
  end

  assign motor_esteira                = motor_q;
  assign esteira_concluida_enchimento = concl_q[0];
  assign esteira_concluida_cq         = concl_q[1];
  assign esteira_concluida_final      = concl_q[2];
  assign destino_atual                = destino_q;
`ifdef ESTEIRA_WATCHDOG_EN
  assign erro_timeout                 = erro_q;
`else
  assign erro_timeout                 = 1'b0;
`endif

endmodule

// File: tb/tb_fsm_esteira_arbitro.sv
// Directed bench for fsm_esteira_arbitro; completion pulses are checked against a scoreboard
// of expected (destination, cycle) entries pushed when each move is stimulated.
module tb_fsm_esteira_arbitro;

  logic       clk;
  logic       reset;
  logic       cmd_ench, cmd_cq, cmd_final;
  logic       sen_ench, sen_cq, sen_final;
  logic       alarme;
  logic       motor;
  logic       conc_ench, conc_cq, conc_final;
  logic [1:0] destino;
  logic       erro;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int t0     = 0;

  typedef struct {
    int unsigned dest;
    int          cyc;
  } exp_t;
  exp_t sb[$];

  fsm_esteira_arbitro #(
    .PARADA_CICLOS (3),
    .TIMEOUT_CICLOS(20)
  ) dut (
    .clk                         (clk),
    .reset                       (reset),
    .cmd_mover_para_enchimento   (cmd_ench),
    .cmd_mover_para_cq           (cmd_cq),
    .cmd_mover_para_final        (cmd_final),
    .sensor_enchimento           (sen_ench),
    .sensor_cq                   (sen_cq),
    .sensor_final                (sen_final),
    .alarme_rolha                (alarme),
    .motor_esteira               (motor),
    .esteira_concluida_enchimento(conc_ench),
    .esteira_concluida_cq        (conc_cq),
    .esteira_concluida_final     (conc_final),
    .destino_atual               (destino),
    .erro_timeout                (erro)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Advance to cycle c relative to the grant edge of the current move.
  task automatic at(input int c);
    while (cyc < t0 + c) tick();
  endtask

  task automatic push(input int unsigned d, input int c);
    exp_t e;
    e.dest = d;
    e.cyc  = t0 + c;
    sb.push_back(e);
  endtask

  logic [2:0] concl;
  assign concl = {conc_final, conc_cq, conc_ench};

  always @(negedge clk) begin
    exp_t e;
    if (concl != 3'b000) begin
      chk("pulse_onehot", $countones(concl), 1);
      if (sb.size() == 0) begin
        chk("unexpected_pulse", {29'b0, concl}, 0);
      end else begin
        e = sb.pop_front();
        chk("pulse_dest", {29'b0, concl}, 32'(3'b001 << e.dest));
        chk("pulse_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "bench time limit");
  end

  initial begin
    reset = 1'b1;
    {cmd_ench, cmd_cq, cmd_final} = '0;
    {sen_ench, sen_cq, sen_final} = '0;
    alarme = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    chk("rst_motor", motor, 0);
    chk("rst_concl", concl, 0);
    chk("rst_destino", destino, 3);
    chk("rst_erro", erro, 0);

    // Normal move to QC, sensor raised before edge 10
    cmd_cq = 1'b1;
    tick(); t0 = cyc;
    push(1, 16);
    chk("norm_motor_c0", motor, 0);
    at(1);  chk("norm_motor_c1", motor, 1); chk("norm_destino", destino, 1);
    at(9);  sen_cq = 1'b1;
    at(12); chk("norm_motor_c12", motor, 1);
    at(13); chk("norm_motor_c13", motor, 0);
    at(18); chk("norm_destino_hold", destino, 1);
    cmd_cq = 1'b0; sen_cq = 1'b0;
    at(20); chk("norm_idle", destino, 3);

    // Priority: enchimento wins over final; final sensor ignored
    cmd_final = 1'b1; cmd_ench = 1'b1;
    tick(); t0 = cyc;
    push(0, 13);
    at(1);  chk("prio_destino", destino, 0); chk("prio_motor", motor, 1);
    at(2);  sen_final = 1'b1;
    at(6);  chk("prio_ignore_other", motor, 1);
    sen_ench = 1'b1;
    at(9);  chk("prio_motor_c9", motor, 1);
    at(10); chk("prio_motor_c10", motor, 0);
    at(15); {cmd_ench, cmd_final, sen_ench, sen_final} = '0;
    at(17); chk("prio_idle", destino, 3);

    // Pause for 5 cycles mid-move, then complete
    cmd_cq = 1'b1;
    tick(); t0 = cyc;
    push(1, 19);
    at(3);  alarme = 1'b1;
    at(4);  chk("pause_motor_c4", motor, 1);
    at(5);  chk("pause_motor_c5", motor, 0);
    at(8);  alarme = 1'b0;
    at(9);  chk("pause_motor_c9", motor, 0);
    at(10); chk("pause_resume", motor, 1);
    at(12); sen_cq = 1'b1;
    at(22); chk("pause_no_err", erro, 0);
    cmd_cq = 1'b0; sen_cq = 1'b0;
    at(24); chk("pause_idle", destino, 3);

    // Timeout with a 3-cycle pause: 20 motor-on cycles end at cycle 23
    cmd_final = 1'b1;
    tick(); t0 = cyc;
    at(5);  alarme = 1'b1;
    at(8);  alarme = 1'b0;
    at(23); chk("tmo_motor_c23", motor, 1); chk("tmo_erro_c23", erro, 0);
`ifdef ESTEIRA_WATCHDOG_EN
    at(24); chk("tmo_motor_c24", motor, 0); chk("tmo_erro_c24", erro, 1);
    cmd_final = 1'b0;
    at(30); chk("tmo_sticky_erro", erro, 1); chk("tmo_sticky_motor", motor, 0);
`else
    at(24); chk("nowd_motor_c24", motor, 1); chk("nowd_erro_c24", erro, 0);
    cmd_final = 1'b0;
    at(30); chk("nowd_erro", erro, 0); chk("nowd_motor", motor, 0);
`endif
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("tmo_rst_erro", erro, 0);
    chk("tmo_rst_destino", destino, 3);
    chk("tmo_rst_motor", motor, 0);

    // Abort in MOVENDO: no pulse
    cmd_ench = 1'b1;
    tick(); t0 = cyc;
    at(4);  cmd_ench = 1'b0;
    at(6);  chk("abort_motor", motor, 0); chk("abort_destino", destino, 3);
    at(12);

    // Reset during PARADA: no pulse, outputs at reset values
    cmd_cq = 1'b1;
    tick(); t0 = cyc;
    at(2);  sen_cq = 1'b1;
    at(6);  chk("rstp_in_parada", destino, 1);
    reset = 1'b1; cmd_cq = 1'b0; sen_cq = 1'b0;
    at(7);  chk("rstp_motor", motor, 0); chk("rstp_destino", destino, 3);
    chk("rstp_concl", concl, 0); chk("rstp_erro", erro, 0);
    reset = 1'b0;
    at(14);

    // Held command: one pulse, no re-grant until released
    cmd_final = 1'b1;
    tick(); t0 = cyc;
    push(2, 8);
    at(1);  sen_final = 1'b1;
    at(3);  sen_final = 1'b0;
    at(20); chk("held_motor", motor, 0); chk("held_destino", destino, 2);
    cmd_final = 1'b0; sen_final = 1'b1;
    at(22); chk("held_idle", destino, 3);
    // Re-issue with the destination sensor already synchronized high
    cmd_final = 1'b1;
    tick(); t0 = cyc;
    push(2, 5);
    chk("pre_motor_c0", motor, 0);
    at(1);  chk("pre_motor_c1", motor, 1);
    at(2);  chk("pre_motor_c2", motor, 0);
    at(8);  cmd_final = 1'b0; sen_final = 1'b0;
    at(10); chk("pre_idle", destino, 3);

    repeat (4) tick();
    chk("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
